// File: rtl/game_ctrl.sv
// Per-frame game sequencer: turns frame_tick into the update strobe and runs the
// idle/playing/crashed/restart FSM that drives the character, speed ramp and score.
module game_ctrl #(
  parameter int FRAMES_PER_SEC    = 60,
  parameter int INIT_SPEED        = 6,
  parameter int MAX_SPEED         = 13,
  parameter int ACCEL_FRAMES      = 600,
  parameter int SCORE_FRAMES      = 6,
  parameter int MAX_SCORE         = 99999,
  parameter int CRASH_HOLD_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_jump,
  input  logic        collide,
  output logic        update,
  output logic [5:0]  timer,
  output logic [4:0]  speed,
  output logic        jump,
  output logic        crash,
  output logic        game_rst,
  output logic [16:0] score,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    CRASHED = 2'd2,
    RESTART = 2'd3
  } state_t;

  localparam int ACC_W  = $clog2(ACCEL_FRAMES + 1);
  localparam int SCNT_W = $clog2(SCORE_FRAMES + 1);
  localparam int HOLD_W = $clog2(CRASH_HOLD_FRAMES + 1);

  localparam logic [ACC_W-1:0]  ACC_LAST   = ACC_W'(ACCEL_FRAMES - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST  = SCNT_W'(SCORE_FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(CRASH_HOLD_FRAMES);
  localparam logic [5:0]        TIMER_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [4:0]        SPEED_INIT = 5'(INIT_SPEED);
  localparam logic [4:0]        SPEED_MAX  = 5'(MAX_SPEED);
  localparam logic [16:0]       SCORE_MAX  = 17'(MAX_SCORE);

  state_t             state_reg, state_next;
  logic [1:0]         sync_reg;
  logic               btn_prev_reg;
  logic               pending_reg, pending_next;
  logic               defer_reg, defer_next;
  logic               restart_done_reg, restart_done_next;
  logic [HOLD_W-1:0]  hold_reg, hold_next;
  logic [ACC_W-1:0]   accel_reg, accel_next;
  logic [SCNT_W-1:0]  scnt_reg, scnt_next;
  logic [4:0]         speed_reg, speed_next;
  logic [16:0]        score_reg, score_next;
  logic [5:0]         timer_reg, timer_next;
  logic               update_reg, update_next;
  logic               jump_reg, jump_next;
  logic               crash_reg, crash_next;
  logic               game_rst_reg, game_rst_next;

  logic btn_sync;
  logic btn_edge;
  logic tick_eff;

  assign btn_sync = sync_reg[1];
  assign btn_edge = btn_sync & ~btn_prev_reg;
  // Ticks seen during RESTART are held back and replayed once back in IDLE.
  assign tick_eff = (state_reg != RESTART) & (frame_tick | defer_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      sync_reg         <= 2'b00;
      btn_prev_reg     <= 1'b0;
      pending_reg      <= 1'b0;
      defer_reg        <= 1'b0;
      restart_done_reg <= 1'b0;
      hold_reg         <= '0;
      accel_reg        <= '0;
      scnt_reg         <= '0;
      speed_reg        <= SPEED_INIT;
      score_reg        <= '0;
      timer_reg        <= '0;
      update_reg       <= 1'b0;
      jump_reg         <= 1'b0;
      crash_reg        <= 1'b0;
      game_rst_reg     <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sync_reg         <= {sync_reg[0], btn_jump};
      btn_prev_reg     <= btn_sync;
      pending_reg      <= pending_next;
      defer_reg        <= defer_next;
      restart_done_reg <= restart_done_next;
      hold_reg         <= hold_next;
      accel_reg        <= accel_next;
      scnt_reg         <= scnt_next;
      speed_reg        <= speed_next;
      score_reg        <= score_next;
      timer_reg        <= timer_next;
      update_reg       <= update_next;
      jump_reg         <= jump_next;
      crash_reg        <= crash_next;
      game_rst_reg     <= game_rst_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    pending_next      = pending_reg | btn_edge;
    defer_next        = defer_reg;
    restart_done_next = restart_done_reg;
    hold_next         = hold_reg;
    accel_next        = accel_reg;
    scnt_next         = scnt_reg;
    speed_next        = speed_reg;
    score_next        = score_reg;
    timer_next        = timer_reg;
    update_next       = tick_eff;
    jump_next         = 1'b0;
    crash_next        = 1'b0;
    game_rst_next     = 1'b0;

    if (tick_eff) begin
      timer_next = (timer_reg == TIMER_LAST) ? 6'd0 : timer_reg + 6'd1;
    end

    case (state_reg)
      IDLE: begin
        if (tick_eff) begin
          defer_next = 1'b0;
          if (pending_reg) begin
            jump_next    = 1'b1;
            pending_next = btn_edge;
            state_next   = PLAYING;
          end
        end
      end

      PLAYING: begin
        if (tick_eff) begin
          if (accel_reg == ACC_LAST) begin
            accel_next = '0;
            if (speed_reg < SPEED_MAX) speed_next = speed_reg + 5'd1;
          end else begin
            accel_next = accel_reg + 1'b1;
          end
          if (scnt_reg == SCNT_LAST) begin
            scnt_next = '0;
            if (score_reg < SCORE_MAX) score_next = score_reg + 17'd1;
          end else begin
            scnt_next = scnt_reg + 1'b1;
          end
          pending_next = btn_edge;
          if (collide) begin
            crash_next = 1'b1;
            hold_next  = '0;
            state_next = CRASHED;
          end else begin
            jump_next = pending_reg | btn_sync;
          end
        end
      end

      CRASHED: begin
        // Presses during the hold window are dropped so a panicked mash
        // right after the crash does not restart the game.
        if (hold_reg < HOLD_MAX) pending_next = 1'b0;
        if (tick_eff) begin
          crash_next = 1'b1;
          if ((hold_reg == HOLD_MAX) && pending_reg) begin
            state_next = RESTART;
          end else if (hold_reg < HOLD_MAX) begin
            hold_next = hold_reg + 1'b1;
          end
        end
      end

      RESTART: begin
        if (frame_tick) defer_next = 1'b1;
        if (!restart_done_reg) begin
          game_rst_next     = 1'b1;
          speed_next        = SPEED_INIT;
          score_next        = '0;
          timer_next        = '0;
          accel_next        = '0;
          scnt_next         = '0;
          restart_done_next = 1'b1;
        end else begin
          restart_done_next = 1'b0;
          state_next        = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign update   = update_reg;
  assign timer    = timer_reg;
  assign speed    = speed_reg;
  assign jump     = jump_reg;
  assign crash    = crash_reg;
  assign game_rst = game_rst_reg;
  assign score    = score_reg;
  assign state    = state_reg;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a frame-level game model predicts every update
// cycle; explicit checks cover reset, ramp end points and the restart pulse.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_jump = 1'b0;
  logic        collide = 1'b0;
  logic        update;
  logic [5:0]  timer;
  logic [4:0]  speed;
  logic        jump;
  logic        crash;
  logic        game_rst;
  logic [16:0] score;
  logic [1:0]  state;

  game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_jump   (btn_jump),
    .collide    (collide),
    .update     (update),
    .timer      (timer),
    .speed      (speed),
    .jump       (jump),
    .crash      (crash),
    .game_rst   (game_rst),
    .score      (score),
    .state      (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic        crash;
    logic [1:0]  st;
    logic [5:0]  tim;
    logic [4:0]  spd;
    logic [16:0] sc;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_tick = 0;
  int n_upd = 0;
  bit verbose = 1'b1;
  logic exp_update = 1'b0;

  int m_state, m_pending, m_hold, m_accel, m_scnt, m_speed, m_score, m_timer;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pending = 0; m_hold = 0; m_accel = 0;
    m_scnt = 0; m_speed = 6; m_score = 0; m_timer = 0;
  endtask

  // One frame_tick with the model advanced and the expected update pushed.
  task automatic do_tick(input logic col, input int gap);
    exp_t e;
    @(negedge clk);
    frame_tick = 1'b1;
    collide    = col;
    e.jump  = 1'b0;
    e.crash = 1'b0;
    m_timer = (m_timer + 1) % 60;
    case (m_state)
      0: if (m_pending != 0) begin
        e.jump = 1'b1; m_state = 1; m_pending = 0;
      end
      1: begin
        m_accel++;
        if (m_accel == 600) begin m_accel = 0; if (m_speed < 13) m_speed++; end
        m_scnt++;
        if (m_scnt == 6) begin m_scnt = 0; if (m_score < 99999) m_score++; end
        if (col) begin
          e.crash = 1'b1; m_state = 2; m_hold = 0; m_pending = 0;
        end else begin
          e.jump = (m_pending != 0); m_pending = 0;
        end
      end
      2: begin
        e.crash = 1'b1;
        if (m_hold == 30 && m_pending != 0) m_state = 3;
        else if (m_hold < 30) m_hold++;
      end
      default: ;
    endcase
    e.st  = 2'(m_state);
    e.tim = 6'(m_timer);
    e.spd = 5'(m_speed);
    e.sc  = 17'(m_score);
    sb.push_back(e);
    n_tick++;
    @(negedge clk);
    frame_tick = 1'b0;
    collide    = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk);
    btn_jump = 1'b1;
    repeat (3) @(negedge clk);
    btn_jump = 1'b0;
    repeat (4) @(negedge clk);
    if (m_state != 2 || m_hold == 30) m_pending = 1;
    $display("press  t=%0t state=%0d pending_model=%0d", $time, m_state, m_pending);
  endtask

  always @(posedge clk) exp_update <= frame_tick & ~rst;

  always @(negedge clk) begin
    exp_t e;
    check_val("update_latency", update, exp_update);
    if (update) begin
      n_upd++;
      check_val("sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (verbose)
          $display("update t=%0t state=%0d jump=%0d crash=%0d timer=%0d speed=%0d score=%0d",
                   $time, state, jump, crash, timer, speed, score);
        check_val("jump",  jump,  e.jump);
        check_val("crash", crash, e.crash);
        check_val("state", state, e.st);
        check_val("timer", timer, e.tim);
        check_val("speed", speed, e.spd);
        check_val("score", score, e.sc);
      end
    end else begin
      check_val("cmd_quiet", {jump, crash}, 0);
    end
  end

  initial begin
    bit seen;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_state", state, 0);
    check_val("rst_speed", speed, 6);
    check_val("rst_score", score, 0);
    check_val("rst_timer", timer, 0);
    check_val("rst_game_rst", game_rst, 0);

    // Idle frames, then a press starts the game.
    repeat (3) do_tick(1'b0, 98);
    press();
    do_tick(1'b0, 98);

    // Timer wrap and speed/score ramp.
    repeat (60) do_tick(1'b0, 2);
    verbose = 1'b0;
    repeat (1140) do_tick(1'b0, 1);
    check_val("ramp_speed_1200", speed, 8);
    check_val("ramp_score_1200", score, 200);
    repeat (8800) do_tick(1'b0, 1);
    check_val("ramp_speed_sat", speed, 13);
    check_val("ramp_score_10000", score, 1666);
    verbose = 1'b1;

    // Crash with a simultaneous jump request, then the hold window.
    press();
    do_tick(1'b1, 4);
    repeat (10) do_tick(1'b0, 4);
    press();
    repeat (25) do_tick(1'b0, 4);
    press();
    do_tick(1'b0, 0);

    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (game_rst) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("game_rst_seen", seen, 1);
    check_val("restart_state", state, 3);
    check_val("restart_speed", speed, 6);
    check_val("restart_score", score, 0);
    check_val("restart_timer", timer, 0);
    @(negedge clk);
    check_val("post_restart_state", state, 0);
    check_val("game_rst_one_cycle", game_rst, 0);
    m_state = 0; m_speed = 6; m_score = 0; m_timer = 0; m_accel = 0; m_scnt = 0; m_hold = 0;
    repeat (5) @(negedge clk);
    do_tick(1'b0, 10);
    repeat (3) do_tick(1'b0, 10);

    // Reset coinciding with a frame tick.
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_val("midrst_update", update, 0);
    check_val("midrst_state", state, 0);
    check_val("midrst_speed", speed, 6);
    check_val("midrst_score", score, 0);
    check_val("midrst_timer", timer, 0);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    do_tick(1'b0, 10);

    repeat (5) @(negedge clk);
    check_val("sb_drained", sb.size(), 0);
    check_val("update_count", n_upd, n_tick);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer that drives the T-rex character and the rest of the game datapath once per video frame.
- Converts the raw frame tick into the single-cycle `update` strobe plus a 0..59 animation `timer`.
- Owns the game FSM: idle, playing, crashed, restart. Produces `jump`/`crash` commands, the speed ramp, the score, and a `game_rst` pulse that re-initialises the character and obstacles between games.

Parameters:
- FRAMES_PER_SEC, 60, timer wrap value; timer counts 0..FRAMES_PER_SEC-1.
- INIT_SPEED, 6, speed loaded at reset and on restart.
- MAX_SPEED, 13, speed saturation value.
- ACCEL_FRAMES, 600, PLAYING frames per +1 speed step.
- SCORE_FRAMES, 6, PLAYING frames per +1 score.
- MAX_SCORE, 99999, score saturation value.
- CRASH_HOLD_FRAMES, 30, frames after crash during which restart requests are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- btn_jump  in  1  asynchronous jump button, active-high
- collide  in  1  collision flag from hit detection, sampled on frame_tick
- update  out  1  one-cycle per-frame strobe to character/obstacles
- timer  out  6  frame counter 0..59
- speed  out  5  current game speed
- jump  out  1  jump/start command, valid in update cycle
- crash  out  1  crash command, valid in update cycle
- game_rst  out  1  one-cycle game reinitialisation pulse
- score  out  17  binary score
- state  out  2  IDLE=0, PLAYING=1, CRASHED=2, RESTART=3

Behaviour:
- Reset values: state IDLE; update, jump, crash, game_rst = 0; timer 0; speed INIT_SPEED; score 0; all internal counters and the pending flag 0.
- Button input path:
  - 2-FF synchroniser, then rising-edge detect.
  - An edge sets `pending`. `pending` clears in the update cycle that consumes it.
  - An edge arriving in the same cycle as consumption keeps `pending` set.
- Frame timing:
  - `update` is asserted exactly one cycle after frame_tick (1-cycle latency).
  - In that same cycle: timer = (timer+1) mod FRAMES_PER_SEC; `jump`/`crash` are valid; both are 0 whenever update=0.
  - A frame_tick arriving while update=1 is handled normally. Back-to-back ticks give back-to-back updates.
- Decisions at frame_tick. The FSM evaluates on frame_tick and its outputs appear in the following update cycle.
  - IDLE:
    - pending=1 → jump=1, go to PLAYING, clear pending.
    - Otherwise stay in IDLE with jump=0.
  - PLAYING:
    - collide=1 → crash=1, jump=0, go to CRASHED, hold counter := 0. Crash takes priority over jump in the same frame.
    - Otherwise jump = pending | synchronised button level, and pending clears.
    - Accel counter increments each frame. At ACCEL_FRAMES-1 it wraps to 0 and speed += 1, saturating at MAX_SPEED.
    - Score counter increments each frame. At SCORE_FRAMES-1 it wraps and score += 1, saturating at MAX_SCORE.
  - CRASHED:
    - crash=1 on every update.
    - Hold counter increments per frame, saturating at CRASH_HOLD_FRAMES.
    - Edges while the counter is below CRASH_HOLD_FRAMES are discarded: pending is forced to 0.
    - Once the hold has expired, pending=1 at frame_tick → go to RESTART. pending is left set.
  - RESTART:
    - The cycle after entry: game_rst=1 for one cycle; speed := INIT_SPEED; score, timer, accel and score counters := 0.
    - Next cycle: go to IDLE. pending is still 1, so the next frame_tick issues jump and the game starts again.
    - frame_tick arriving while in RESTART is deferred and processed from IDLE.
- Speed, score and the accel/score counters only change in PLAYING and on reset/restart.
- `collide` is ignored outside PLAYING.
- rst asserted mid-frame or mid-restart overrides everything: reset values next cycle and no update pulse.

Test Plan:
- Idle start: reset; frame_tick every 100 cycles; press button once → first frame_tick after the edge gives update=1, jump=1 and state=1 next cycle. Previous frames show jump=0.
- Timer wrap: 60 ticks in PLAYING → timer sequence 1..59, 0, with exactly one update per tick at latency 1.
- Speed/score ramp: 1200 frames in PLAYING without collision → speed=8, score=200. Forcing 10000 frames → speed saturates at 13.
- Crash priority: collide=1 and a button edge in the same frame → crash=1, jump=0, state=2. Every later update has crash=1, and speed/score are frozen.
- Crash hold: a button edge at crash frame +10 is ignored. An edge at +35 → RESTART, then one-cycle game_rst with speed=6 and score=0, then IDLE. The next tick gives jump=1 and PLAYING.
- Reset mid-game: rst asserted in the same cycle as frame_tick → no update that frame; all outputs at their reset values.
